// File: rtl/fir_ctrl_if.sv
// AXI-Lite bundle between the configuration master and the FIR control block.
// The write response channel is intentionally absent.
interface fir_ctrl_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   awvalid;
  logic                   awready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   wvalid;
  logic                   wready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   arvalid;
  logic                   arready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, araddr, arvalid, rready,
    input  awready, wready, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, araddr, arvalid, rready,
    output awready, wready, arready, rdata, rvalid
  );
endinterface

// File: rtl/fir_ctrl.sv
// FIR control front-end: AXI-Lite register map, ap_start/ap_done/ap_idle sequencing
// and arbitration of the single tap BRAM port between AXI-Lite and the engine.
module fir_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  fir_ctrl_if.slave              axi,
  output logic                   ap_start,
  input  logic                   eng_done,
  output logic [pDATA_WIDTH-1:0] data_length,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic [pDATA_WIDTH-1:0] eng_tap_Do,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);
  localparam int IW = pADDR_WIDTH - 2;
  localparam logic [IW-1:0] IDX_CTRL   = IW'(32'd0);
  localparam logic [IW-1:0] IDX_LEN    = IW'(32'd4);
  localparam logic [IW-1:0] IDX_TAP_LO = IW'(32'd8);
  localparam logic [IW-1:0] IDX_TAP_HI = IW'(32'd8 + 32'(Tape_Num) - 32'd1);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE = pADDR_WIDTH'(32'h20);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_RUN = 2'd2} state_e;
  typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_CTRL = 2'd1, SEL_LEN = 2'd2, SEL_TAP = 2'd3} sel_e;

  function automatic sel_e decode(input logic [IW-1:0] idx);
    if (idx == IDX_CTRL) begin
      decode = SEL_CTRL;
    end else if (idx == IDX_LEN) begin
      decode = SEL_LEN;
    end else if ((idx >= IDX_TAP_LO) && (idx <= IDX_TAP_HI)) begin
      decode = SEL_TAP;
    end else begin
      decode = SEL_NONE;
    end
  endfunction

  function automatic logic [pADDR_WIDTH-1:0] tap_offset(input logic [pADDR_WIDTH-1:0] addr);
    logic [pADDR_WIDTH-1:0] off;
    off = addr - TAP_BASE;
    tap_offset = {off[pADDR_WIDTH-1:2], 2'b00};
  endfunction

  state_e                 state_q, state_d;
  logic                   ap_start_q, ap_start_d;
  logic                   ap_done_q, ap_done_d;
  logic                   wr_rdy_q, wr_rdy_d;
  logic                   ar_rdy_q, ar_rdy_d;
  logic                   rd_pend_q, rd_pend_d;
  sel_e                   rd_sel_q, rd_sel_d;
  logic                   rd_eng_q, rd_eng_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rd_tap_q, rd_tap_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [3:0]             tap_we_q, tap_we_d;
  logic [pADDR_WIDTH-1:0] tap_a_q, tap_a_d;
  logic [pDATA_WIDTH-1:0] tap_di_q, tap_di_d;
  logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;

  logic wr_fire, rd_fire, rd_busy, eng_owns, rd_clear, start_req;
  sel_e wr_sel, ar_sel;

  // Handshake qualifiers and address decode for the current cycle
  always_comb begin
    wr_fire   = wr_rdy_q && axi.awvalid && axi.wvalid;
    rd_fire   = ar_rdy_q && axi.arvalid;
    rd_busy   = ar_rdy_q || rd_pend_q || rvalid_q;
    eng_owns  = (state_q != S_IDLE);
    wr_sel    = decode(axi.awaddr[pADDR_WIDTH-1:2]);
    ar_sel    = decode(axi.araddr[pADDR_WIDTH-1:2]);
    rd_clear  = rvalid_q && axi.rready && (rd_sel_q == SEL_CTRL);
    start_req = wr_fire && (wr_sel == SEL_CTRL) && axi.wdata[0];
  end

  // Next-state logic for the channels, register file, tap port and sequencing FSM
  always_comb begin
    state_d       = state_q;
    ap_start_d    = 1'b0;
    ap_done_d     = rd_clear ? 1'b0 : ap_done_q;
    // Writes win over a simultaneous read request; both wait for any read in flight.
    wr_rdy_d      = axi.awvalid && axi.wvalid && !wr_rdy_q && !rd_busy;
    ar_rdy_d      = axi.arvalid && !ar_rdy_q && !wr_rdy_d && !rd_busy;
    rd_pend_d     = 1'b0;
    rd_sel_d      = rd_sel_q;
    rd_eng_d      = rd_eng_q;
    rvalid_d      = rvalid_q;
    rd_tap_d      = rd_tap_q;
    rdata_d       = rdata_q;
    tap_we_d      = 4'h0;
    tap_a_d       = tap_a_q;
    tap_di_d      = tap_di_q;
    data_length_d = data_length_q;

    if (wr_fire && (wr_sel == SEL_LEN) && !eng_owns) begin
      data_length_d = axi.wdata;
    end else begin
      data_length_d = data_length_q;
    end

    if (wr_fire && (wr_sel == SEL_TAP) && !eng_owns) begin
      tap_we_d = 4'hF;
      tap_a_d  = tap_offset(axi.awaddr);
      tap_di_d = axi.wdata;
    end else if (rd_fire && (ar_sel == SEL_TAP) && !eng_owns) begin
      tap_a_d  = tap_offset(axi.araddr);
    end else begin
      tap_we_d = 4'h0;
    end

    if (rd_fire) begin
      rd_pend_d = 1'b1;
      rd_sel_d  = ar_sel;
      rd_eng_d  = eng_owns;
    end else begin
      rd_pend_d = 1'b0;
    end

    // Tap reads forward tap_Do live while rvalid is up and latch it at the handshake.
    if (rd_pend_q) begin
      rvalid_d = 1'b1;
      rd_tap_d = (rd_sel_q == SEL_TAP) && !rd_eng_q;
      case (rd_sel_q)
        SEL_CTRL: rdata_d = pDATA_WIDTH'({(state_q == S_IDLE), ap_done_q, (state_q != S_IDLE)});
        SEL_LEN:  rdata_d = data_length_q;
        SEL_TAP:  rdata_d = rd_eng_q ? {pDATA_WIDTH{1'b1}} : rdata_q;
        default:  rdata_d = {pDATA_WIDTH{1'b0}};
      endcase
    end else if (rvalid_q && axi.rready) begin
      rvalid_d = 1'b0;
      rd_tap_d = 1'b0;
      rdata_d  = rd_tap_q ? tap_Do : rdata_q;
    end else begin
      rvalid_d = rvalid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d    = S_START;
          ap_start_d = 1'b1;
          ap_done_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d   = S_RUN;
        ap_done_d = 1'b0;
      end
      S_RUN: begin
        if (eng_done) begin
          state_d   = S_IDLE;
          ap_done_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register for the whole block
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q       <= S_IDLE;
      ap_start_q    <= 1'b0;
      ap_done_q     <= 1'b0;
      wr_rdy_q      <= 1'b0;
      ar_rdy_q      <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_sel_q      <= SEL_NONE;
      rd_eng_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      rd_tap_q      <= 1'b0;
      rdata_q       <= {pDATA_WIDTH{1'b0}};
      tap_we_q      <= 4'h0;
      tap_a_q       <= {pADDR_WIDTH{1'b0}};
      tap_di_q      <= {pDATA_WIDTH{1'b0}};
      data_length_q <= {pDATA_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      ap_start_q    <= ap_start_d;
      ap_done_q     <= ap_done_d;
      wr_rdy_q      <= wr_rdy_d;
      ar_rdy_q      <= ar_rdy_d;
      rd_pend_q     <= rd_pend_d;
      rd_sel_q      <= rd_sel_d;
      rd_eng_q      <= rd_eng_d;
      rvalid_q      <= rvalid_d;
      rd_tap_q      <= rd_tap_d;
      rdata_q       <= rdata_d;
      tap_we_q      <= tap_we_d;
      tap_a_q       <= tap_a_d;
      tap_di_q      <= tap_di_d;
      data_length_q <= data_length_d;
    end
  end

  assign axi.awready = wr_rdy_q;
  assign axi.wready  = wr_rdy_q;
  assign axi.arready = ar_rdy_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rd_tap_q ? tap_Do : rdata_q;
  assign ap_start    = ap_start_q;
  assign data_length = data_length_q;
  assign eng_tap_Do  = tap_Do;
  assign tap_EN      = 1'b1;
  assign tap_Di      = tap_di_q;
  assign tap_WE      = (state_q == S_RUN) ? 4'h0 : tap_we_q;
  assign tap_A       = (state_q == S_RUN) ? eng_tap_A : tap_a_q;
endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl: table of register/tap accesses plus hand-written
// sequences for start/done, arbitration, backpressure and reset corner cases.
module tb_fir_ctrl;
  logic        axis_clk;
  logic        axis_rst_n;
  logic        ap_start;
  logic        eng_done;
  logic [31:0] data_length;
  logic [11:0] eng_tap_A;
  logic [31:0] eng_tap_Do;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di;
  logic [11:0] tap_A;
  logic [31:0] tap_Do;
  logic [31:0] bram [0:15];

  int pass_cnt = 0;
  int total_cnt = 0;

  fir_ctrl_if axi_if ();

  fir_ctrl dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .axi        (axi_if),
    .ap_start   (ap_start),
    .eng_done   (eng_done),
    .data_length(data_length),
    .eng_tap_A  (eng_tap_A),
    .eng_tap_Do (eng_tap_Do),
    .tap_WE     (tap_WE),
    .tap_EN     (tap_EN),
    .tap_Di     (tap_Di),
    .tap_A      (tap_A),
    .tap_Do     (tap_Do)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  // Tap BRAM with one cycle of read latency
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) bram[tap_A[5:2]] <= tap_Di;
      tap_Do <= bram[tap_A[5:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           output logic [3:0] we1, output logic [11:0] ta1, output logic [31:0] di1,
                           output logic st1, output logic [3:0] we2, output logic st2);
    int n;
    axi_if.awaddr = a; axi_if.wdata = d; axi_if.awvalid = 1'b1; axi_if.wvalid = 1'b1;
    n = 0;
    @(negedge axis_clk);
    while (!axi_if.awready && n < 20) begin @(negedge axis_clk); n++; end
    chk("awready_seen", {31'd0, axi_if.awready & axi_if.wready}, 32'd1);
    @(negedge axis_clk);
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    chk("aw_w_pulse_width", {30'd0, axi_if.awready, axi_if.wready}, 32'd0);
    we1 = tap_WE; ta1 = tap_A; di1 = tap_Di; st1 = ap_start;
    @(negedge axis_clk);
    we2 = tap_WE; st2 = ap_start;
  endtask

  task automatic axi_read(input logic [11:0] a, input int hold, input logic pulse_done,
                          output logic [31:0] d);
    int n;
    logic stable;
    axi_if.araddr = a; axi_if.arvalid = 1'b1; axi_if.rready = 1'b0;
    n = 0;
    @(negedge axis_clk);
    while (!axi_if.arready && n < 20) begin @(negedge axis_clk); n++; end
    chk("arready_seen", {31'd0, axi_if.arready}, 32'd1);
    @(negedge axis_clk);
    axi_if.arvalid = 1'b0;
    chk("arready_pulse_rvalid_early", {30'd0, axi_if.arready, axi_if.rvalid}, 32'd0);
    @(negedge axis_clk);
    chk("rvalid_latency", {31'd0, axi_if.rvalid}, 32'd1);
    d = axi_if.rdata;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge axis_clk);
      if (axi_if.rvalid !== 1'b1 || axi_if.rdata !== d) stable = 1'b0;
    end
    if (hold > 0) chk("rvalid_rdata_hold", {31'd0, stable}, 32'd1);
    axi_if.rready = 1'b1; eng_done = pulse_done;
    @(negedge axis_clk);
    axi_if.rready = 1'b0; eng_done = 1'b0;
    chk("rvalid_drop", {31'd0, axi_if.rvalid}, 32'd0);
  endtask

  task automatic pulse_eng_done();
    eng_done = 1'b1;
    @(negedge axis_clk);
    eng_done = 1'b0;
    @(negedge axis_clk);
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic [3:0]  exp_we;
    logic [11:0] exp_ta;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [31:0] taps [0:10];
    logic [3:0]  we1, we2;
    logic [11:0] ta1;
    logic [31:0] di1, rd;
    logic        st1, st2;
    logic        any_we;
    int          n;

    taps[0] = 32'd0;          taps[1] = 32'hFFFF_FFF6; taps[2] = 32'hFFFF_FFF7;
    taps[3] = 32'd23;         taps[4] = 32'd56;        taps[5] = 32'd63;
    taps[6] = 32'd56;         taps[7] = 32'd23;        taps[8] = 32'hFFFF_FFF7;
    taps[9] = 32'hFFFF_FFF6;  taps[10] = 32'd0;
    for (int i = 0; i < 11; i++)
      vecs.push_back('{1'b1, 12'h020 + 12'(4 * i), taps[i], 32'd0, 4'hF, 12'(4 * i)});
    for (int i = 0; i < 11; i++)
      vecs.push_back('{1'b0, 12'h020 + 12'(4 * i), 32'd0, taps[i], 4'h0, 12'h000});
    vecs.push_back('{1'b1, 12'h010, 32'd600, 32'd0, 4'h0, 12'h000});
    vecs.push_back('{1'b0, 12'h010, 32'd0, 32'd600, 4'h0, 12'h000});
    vecs.push_back('{1'b1, 12'h04C, 32'h1234_5678, 32'd0, 4'h0, 12'h000});
    vecs.push_back('{1'b0, 12'h04C, 32'd0, 32'd0, 4'h0, 12'h000});
    vecs.push_back('{1'b0, 12'h01C, 32'd0, 32'd0, 4'h0, 12'h000});
    vecs.push_back('{1'b0, 12'h000, 32'd0, 32'h4, 4'h0, 12'h000});

    axis_rst_n = 1'b0; eng_done = 1'b0; eng_tap_A = 12'h008;
    axi_if.awaddr = 12'h000; axi_if.awvalid = 1'b0; axi_if.wdata = 32'd0; axi_if.wvalid = 1'b0;
    axi_if.araddr = 12'h000; axi_if.arvalid = 1'b0; axi_if.rready = 1'b0;
    #12;
    chk("reset_handshake", {28'd0, axi_if.awready, axi_if.wready, axi_if.arready, axi_if.rvalid}, 32'd0);
    chk("reset_ap_start_we", {27'd0, ap_start, tap_WE}, 32'd0);
    chk("reset_rdata", axi_if.rdata, 32'd0);
    chk("reset_tap_Di", tap_Di, 32'd0);
    chk("reset_tap_A", {20'd0, tap_A}, 32'd0);
    chk("reset_data_length", data_length, 32'd0);
    chk("tap_EN", {31'd0, tap_EN}, 32'd1);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);

    foreach (vecs[k]) begin
      if (vecs[k].wr) begin
        axi_write(vecs[k].addr, vecs[k].data, we1, ta1, di1, st1, we2, st2);
        chk($sformatf("wr_we_%0h", vecs[k].addr), {28'd0, we1}, {28'd0, vecs[k].exp_we});
        if (vecs[k].exp_we == 4'hF) begin
          chk($sformatf("wr_tap_A_%0h", vecs[k].addr), {20'd0, ta1}, {20'd0, vecs[k].exp_ta});
          chk($sformatf("wr_tap_Di_%0h", vecs[k].addr), di1, vecs[k].data);
        end
        chk($sformatf("wr_we_one_cycle_%0h", vecs[k].addr), {28'd0, we2}, 32'd0);
      end else begin
        axi_read(vecs[k].addr, 0, 1'b0, rd);
        chk($sformatf("rd_%0h", vecs[k].addr), rd, vecs[k].exp);
      end
    end
    chk("eng_tap_Do_forward", eng_tap_Do, tap_Do);

    // Start the engine
    axi_write(12'h000, 32'd1, we1, ta1, di1, st1, we2, st2);
    chk("ap_start_pulse", {31'd0, st1}, 32'd1);
    chk("ap_start_one_cycle", {31'd0, st2}, 32'd0);
    chk("data_length_600", data_length, 32'd600);
    axi_read(12'h000, 0, 1'b0, rd);
    chk("ctrl_in_run", rd, 32'h1);
    chk("tap_A_engine_owned", {20'd0, tap_A}, 32'h008);

    // AXI tap access while the engine owns the port
    axi_write(12'h024, 32'd77, we1, ta1, di1, st1, we2, st2);
    chk("run_tap_write_no_we", {28'd0, we1}, 32'd0);
    axi_read(12'h024, 0, 1'b0, rd);
    chk("run_tap_read_ff", rd, 32'hFFFF_FFFF);
    axi_write(12'h010, 32'd5, we1, ta1, di1, st1, we2, st2);
    chk("run_len_write_ignored", data_length, 32'd600);

    pulse_eng_done();
    axi_read(12'h000, 0, 1'b0, rd);
    chk("ctrl_after_done", rd, 32'h6);
    axi_read(12'h000, 0, 1'b0, rd);
    chk("ctrl_done_cleared", rd, 32'h4);
    axi_read(12'h024, 0, 1'b0, rd);
    chk("tap_1_preserved", rd, 32'hFFFF_FFF6);
    pulse_eng_done();
    axi_read(12'h000, 0, 1'b0, rd);
    chk("eng_done_idle_ignored", rd, 32'h4);

    // eng_done coincides with the clearing read of ap_ctrl
    axi_write(12'h000, 32'd1, we1, ta1, di1, st1, we2, st2);
    axi_read(12'h000, 2, 1'b1, rd);
    chk("coincident_read_value", rd, 32'h1);
    axi_read(12'h000, 0, 1'b0, rd);
    chk("coincident_done_kept", rd, 32'h6);

    // Simultaneous write and read to data_length: write first, read sees new value
    axi_if.awaddr = 12'h010; axi_if.wdata = 32'd123; axi_if.awvalid = 1'b1; axi_if.wvalid = 1'b1;
    axi_if.araddr = 12'h010; axi_if.arvalid = 1'b1; axi_if.rready = 1'b0;
    @(negedge axis_clk);
    chk("arb_write_wins", {30'd0, axi_if.awready, axi_if.arready}, 32'h2);
    @(negedge axis_clk);
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    n = 0;
    while (!axi_if.arready && n < 20) begin @(negedge axis_clk); n++; end
    chk("arb_read_accepted", {31'd0, axi_if.arready}, 32'd1);
    @(negedge axis_clk);
    axi_if.arvalid = 1'b0;
    @(negedge axis_clk);
    chk("arb_rvalid", {31'd0, axi_if.rvalid}, 32'd1);
    rd = axi_if.rdata;
    chk("arb_read_data", rd, 32'd123);
    any_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_clk);
      if (axi_if.rvalid !== 1'b1 || axi_if.rdata !== 32'd123) any_we = 1'b1;
    end
    chk("backpressure_stable", {31'd0, any_we}, 32'd0);
    axi_if.rready = 1'b1;
    @(negedge axis_clk);
    axi_if.rready = 1'b0;
    chk("backpressure_drop", {31'd0, axi_if.rvalid}, 32'd0);
    chk("data_length_123", data_length, 32'd123);

    // Reset during RUN
    axi_write(12'h000, 32'd1, we1, ta1, di1, st1, we2, st2);
    axis_rst_n = 1'b0;
    #1;
    chk("rst_run_outputs", {27'd0, ap_start, tap_WE}, 32'd0);
    chk("rst_run_tap_A", {20'd0, tap_A}, 32'd0);
    chk("rst_run_data_length", data_length, 32'd0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    axi_read(12'h000, 0, 1'b0, rd);
    chk("rst_run_idle", rd, 32'h4);

    // Reset while a tap write is being accepted
    axi_if.awaddr = 12'h028; axi_if.wdata = 32'd999; axi_if.awvalid = 1'b1; axi_if.wvalid = 1'b1;
    n = 0;
    @(negedge axis_clk);
    while (!axi_if.awready && n < 20) begin @(negedge axis_clk); n++; end
    chk("rst_wr_awready_seen", {31'd0, axi_if.awready}, 32'd1);
    axis_rst_n = 1'b0;
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    #1;
    chk("rst_wr_awready_low", {30'd0, axi_if.awready, axi_if.wready}, 32'd0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    any_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (tap_WE != 4'h0) any_we = 1'b1;
      @(negedge axis_clk);
    end
    chk("rst_wr_no_we", {31'd0, any_we}, 32'd0);
    axi_read(12'h028, 0, 1'b0, rd);
    chk("rst_wr_tap_intact", rd, 32'hFFFF_FFF7);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
